// File: rtl/shift_rotate_stage.sv
// Two-stage pipelined shift/rotate unit: stage A captures the request, stage B computes and holds
// the result. Valid/ready handshakes on both sides; full throughput while downstream is ready.
module shift_rotate_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             op_err,
    output logic             busy
);

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam int         SH_W    = 5;

    logic             a_valid_reg;
    logic [2:0]       a_op_reg;
    logic [WIDTH-1:0] a_operand_reg;
    logic [SH_W-1:0]  a_cnt_reg;
    logic             a_sat_reg;

    logic             b_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             op_err_reg;

    logic b_load;
    logic in_xfer;

    // B refills whenever it is empty or its entry leaves on this same edge.
    assign b_load   = a_valid_reg & (~b_valid_reg | out_ready);
    assign in_ready = ~a_valid_reg | b_load;
    assign in_xfer  = in_valid & in_ready;

    always_ff @(posedge clock) begin
        if (clear) begin
            a_valid_reg   <= 1'b0;
            a_op_reg      <= 3'd0;
            a_operand_reg <= '0;
            a_cnt_reg     <= '0;
            a_sat_reg     <= 1'b0;
        end else if (in_xfer) begin
            a_valid_reg   <= 1'b1;
            a_op_reg      <= op;
            a_operand_reg <= operand;
            a_cnt_reg     <= count[SH_W-1:0];
            a_sat_reg     <= |count[CNT_W-1:SH_W];
        end else if (b_load) begin
            a_valid_reg   <= 1'b0;
        end
    end

    // Left ops run through the right-shifter on a bit-reversed operand.
    logic left_op;
    logic rot_op;
    logic fill;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] post;
    logic [SH_W:0][WIDTH-1:0] stage;

    assign left_op = (a_op_reg == OP_SHL) | (a_op_reg == OP_ROL);
    assign rot_op  = (a_op_reg == OP_ROL) | (a_op_reg == OP_ROR);
    assign fill    = (a_op_reg == OP_SHRA) & a_operand_reg[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign pre[gi]  = left_op ? a_operand_reg[WIDTH-1-gi] : a_operand_reg[gi];
            assign post[gi] = left_op ? stage[SH_W][WIDTH-1-gi] : stage[SH_W][gi];
        end
    endgenerate

    assign stage[0] = pre;

    generate
        for (genvar gi = 0; gi < SH_W; gi++) begin : g_barrel
            localparam int SH = 1 << gi;
            assign stage[gi+1] = !a_cnt_reg[gi] ? stage[gi] :
                                 rot_op ? {stage[gi][SH-1:0], stage[gi][WIDTH-1:SH]} :
                                          {{SH{fill}}, stage[gi][WIDTH-1:SH]};
        end
    endgenerate

    logic [WIDTH-1:0] calc_result;
    logic             calc_err;

    always_comb begin
        calc_err    = (a_op_reg > OP_ROR);
        calc_result = post;
        if (calc_err) begin
            calc_result = '0;
        end else if (a_sat_reg && !rot_op) begin
            calc_result = (a_op_reg == OP_SHRA) ? {WIDTH{a_operand_reg[WIDTH-1]}} : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            b_valid_reg <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            op_err_reg  <= 1'b0;
        end else if (b_load) begin
            b_valid_reg <= 1'b1;
            result_reg  <= calc_result;
            zero_reg    <= (calc_result == '0);
            op_err_reg  <= calc_err;
        end else if (out_ready) begin
            b_valid_reg <= 1'b0;
        end
    end

    assign out_valid = b_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign op_err    = op_err_reg;
    assign busy      = a_valid_reg | b_valid_reg;

endmodule

// File: tb/tb_shift_rotate_stage.sv
// Bench for shift_rotate_stage: a queue-based model (capacity two, one-edge visibility delay)
// is compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_shift_rotate_stage;

    logic        clock;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand;
    logic [31:0] count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        op_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    shift_rotate_stage #(.WIDTH(32), .CNT_W(32)) dut (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand(operand), .count(count), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .op_err(op_err), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the operation definitions: {op_err, result}.
    function automatic logic [32:0] ref_calc(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] c);
        int          n;
        bit          sat;
        logic [63:0] d;
        logic [31:0] r;
        n   = int'(c % 32);
        sat = (c > 31);
        d   = {x, x};
        r   = 32'h0;
        case (o)
            3'd0: r = sat ? 32'h0 : (x << n);
            3'd1: r = sat ? 32'h0 : (x >> n);
            3'd2: r = sat ? {32{x[31]}} : 32'($signed(x) >>> n);
            3'd3: begin d = d << n; r = d[63:32]; end
            3'd4: begin d = d >> n; r = d[31:0]; end
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    typedef struct {
        logic [31:0] r;
        logic        e;
        longint      acc;
    } ent_t;

    ent_t   q[$];
    longint edge_n = 0;

    // An entry is visible one full edge after it was accepted; at most two entries are held.
    function automatic bit model_ov();
        return (q.size() > 0) && (q[0].acc + 1 < edge_n);
    endfunction

    function automatic bit model_ir();
        return !(q.size() == 2 && !out_ready);
    endfunction

    always @(posedge clock) begin
        bit          ov;
        bit          ir;
        logic [32:0] rc;
        ent_t        en;
        ov = model_ov();
        ir = model_ir();
        if (clear) begin
            q.delete();
        end else begin
            if (ov && out_ready) void'(q.pop_front());
            if (in_valid && ir) begin
                rc     = ref_calc(op, operand, count);
                en.r   = rc[31:0];
                en.e   = rc[32];
                en.acc = edge_n;
                q.push_back(en);
            end
        end
        edge_n++;
    end

    always @(negedge clock) begin
        if (started) begin
            chk("out_valid", {32'h0, out_valid}, {32'h0, model_ov()});
            chk("in_ready", {32'h0, in_ready}, {32'h0, model_ir()});
            chk("busy", {32'h0, busy}, {32'h0, q.size() > 0});
            if (model_ov()) begin
                chk("result", {1'b0, result}, {1'b0, q[0].r});
                chk("zero", {32'h0, zero}, {32'h0, q[0].r == 32'h0});
                chk("op_err", {32'h0, op_err}, {32'h0, q[0].e});
            end
        end
    end

    task automatic drive_one(input string name, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] c, input logic [31:0] exp_r,
                             input logic exp_z, input logic exp_e);
        bit got;
        @(posedge clock); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = o;
        operand   = a;
        count     = c;
        @(posedge clock); #1;
        in_valid = 1'b0;
        got = 0;
        for (int cyc = 1; cyc < 20 && !got; cyc++) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1;
                chk({name, "_latency"}, 33'(cyc), 33'd2);
                chk({name, "_result"}, {1'b0, result}, {1'b0, exp_r});
                chk({name, "_zero"}, {32'h0, zero}, {32'h0, exp_z});
                chk({name, "_op_err"}, {32'h0, op_err}, {32'h0, exp_e});
                $display("txn %s op=%0d operand=%h count=%0d -> result=%h zero=%b op_err=%b",
                         name, o, a, c, result, zero, op_err);
            end
        end
        if (!got) chk({name, "_timeout"}, 33'd0, 33'd1);
    endtask

    logic [31:0] bp_vals [0:3];
    int idx;
    int outs;

    initial begin
        clear     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'd0;
        operand   = 32'h0;
        count     = 32'h0;

        chk("pin_rol", ref_calc(3'd3, 32'h8000_0001, 32'd1), {1'b0, 32'h0000_0003});
        chk("pin_ror0", ref_calc(3'd4, 32'h1234_5678, 32'd0), {1'b0, 32'h1234_5678});
        chk("pin_ror36", ref_calc(3'd4, 32'h1234_5678, 32'd36), {1'b0, 32'h8123_4567});
        chk("pin_shra_sat", ref_calc(3'd2, 32'h8000_0000, 32'd40), {1'b0, 32'hFFFF_FFFF});
        chk("pin_shl_sat", ref_calc(3'd0, 32'hFFFF_FFFF, 32'd32), {1'b0, 32'h0});
        chk("pin_illegal", ref_calc(3'd6, 32'hDEAD_BEEF, 32'd3), {1'b1, 32'h0});

        repeat (3) @(posedge clock);
        #1;
        clear   = 1'b0;
        started = 1;
        @(negedge clock);
        chk("rst_out_valid", {32'h0, out_valid}, 33'd0);
        chk("rst_result", {1'b0, result}, 33'd0);
        chk("rst_zero", {32'h0, zero}, 33'd0);
        chk("rst_op_err", {32'h0, op_err}, 33'd0);
        chk("rst_busy", {32'h0, busy}, 33'd0);
        chk("rst_in_ready", {32'h0, in_ready}, 33'd1);

        drive_one("rol", 3'd3, 32'h8000_0001, 32'd1, 32'h0000_0003, 1'b0, 1'b0);
        drive_one("ror0", 3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
        drive_one("ror36", 3'd4, 32'h1234_5678, 32'd36, 32'h8123_4567, 1'b0, 1'b0);
        drive_one("shra_sat", 3'd2, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive_one("shl_sat", 3'd0, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 1'b1, 1'b0);
        drive_one("illegal", 3'd6, 32'hDEAD_BEEF, 32'd0, 32'h0000_0000, 1'b1, 1'b1);
        drive_one("after_illegal", 3'd0, 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b0, 1'b0);

        // Backpressure: four SHR ops of 32'hF000_0000 by 4, 8, 12, 16.
        bp_vals[0] = 32'd4; bp_vals[1] = 32'd8; bp_vals[2] = 32'd12; bp_vals[3] = 32'd16;
        @(posedge clock); #1;
        out_ready = 1'b0;
        idx  = 0;
        outs = 0;
        for (int cyc = 0; cyc < 40 && outs < 4; cyc++) begin
            if (cyc == 8) out_ready = 1'b1;
            in_valid = (idx < 4);
            op       = 3'd1;
            operand  = 32'hF000_0000;
            count    = (idx < 4) ? bp_vals[idx] : 32'd0;
            @(negedge clock);
            if (cyc == 3) chk("bp_hold_early", {1'b0, result}, {1'b0, 32'h0F00_0000});
            if (cyc == 7) begin
                chk("bp_accepts", 33'(idx), 33'd2);
                chk("bp_in_ready", {32'h0, in_ready}, 33'd0);
                chk("bp_hold_late", {1'b0, result}, {1'b0, 32'h0F00_0000});
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) outs++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        chk("bp_outputs", 33'(outs), 33'd4);
        $display("txn backpressure accepted=%0d delivered=%0d", idx, outs);

        // Fill both stages under stall, then clear together with a live handshake.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd3;
        operand   = 32'h0000_0001;
        count     = 32'd5;
        repeat (4) @(posedge clock);
        #1;
        @(negedge clock);
        chk("full_in_ready", {32'h0, in_ready}, 33'd0);
        chk("full_busy", {32'h0, busy}, 33'd1);
        @(posedge clock); #1;
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("clr_out_valid", {32'h0, out_valid}, 33'd0);
        chk("clr_busy", {32'h0, busy}, 33'd0);
        chk("clr_result", {1'b0, result}, 33'd0);
        chk("clr_in_ready", {32'h0, in_ready}, 33'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("clr_no_stale", {32'h0, out_valid}, 33'd0);
        end
        $display("txn clear_mid_operation done");

        for (int k = 0; k < 3000; k++) begin
            @(posedge clock); #1;
            clear     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            op        = 3'($urandom_range(0, 7));
            operand   = $urandom;
            count     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
        end
        @(posedge clock); #1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("drain_empty", {32'h0, busy}, 33'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
